seek_e: RTL and testbench
=========================

SEEK_E -- requirements
Module: seek_e

Interface
REQ-001 Parameter DW, default `Datawidth from define.v (14), width of the result e.
REQ-002 Parameter SHIFT, default 3, number of fractional bits removed from f; legal range 1..DW.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 f  input  DW+3  unsigned scaled operand, sampled only on an accepted request.
REQ-006 en  input  1  request strobe, level-sampled each rising edge.
REQ-007 e  output  DW  registered unsigned result: round(f / 2^SHIFT).
REQ-008 rdy  output  1  registered one-cycle pulse, e valid and new.
REQ-009 busy  output  1  registered, high while a conversion is in progress.

Function
REQ-010 States IDLE, SHIFT, DONE; encoding local to the module.
REQ-011 IDLE: en=1 at an edge -> load f into a DW+3-bit work register, clear round bit, load a shift counter with SHIFT, go to SHIFT, busy=1.
REQ-012 IDLE with en=0: stay in IDLE, hold e, rdy=0, busy=0.
REQ-013 SHIFT: each edge shifts the work register right one bit (zero fill), captures the bit shifted out as the round bit, decrements the counter; after the SHIFT-th shift go to DONE.
REQ-014 DONE: sum = work[DW:0] + round bit (DW+1 bits); e <= sum[DW-1:0] or the saturated value (REQ-026/027); rdy <= 1; busy <= 0; go to IDLE.
REQ-015 Rounding is round-half-up on the last discarded bit only; lower discarded bits are ignored.
REQ-016 Work-register bits above DW after shifting make the result overflow, handled as in REQ-026/027.
REQ-017 Latency: en accepted at edge N -> rdy=1 and e valid after edge N+SHIFT+1, for exactly one cycle.
REQ-018 en while busy=1 or in DONE is ignored; it is not queued.
REQ-019 en in the IDLE cycle right after DONE is accepted, giving back-to-back throughput of one result per SHIFT+2 cycles.
REQ-020 f changes after acceptance do not affect the conversion in progress.
REQ-021 e holds its last value between results; it is not cleared when idle.

Reset
REQ-022 rst=1 forces, asynchronously: state IDLE, e=0, rdy=0, busy=0, work register, counter and round bit all 0.
REQ-023 rst mid-conversion aborts it; no rdy pulse is produced for the aborted request.
REQ-024 The first en after rst is released is accepted normally at the next edge.

Configuration
REQ-025 Macro SEEK_E_SAT_EN selects overflow handling.
REQ-026 With SEEK_E_SAT_EN defined: if sum exceeds 2^DW-1 or any bit of work[DW+2:DW] is set, e = 2^DW-1 (all ones).
REQ-027 Without SEEK_E_SAT_EN: e = sum[DW-1:0] (wrap), with no saturation logic synthesized.

Structure
REQ-028 DW default and the SHIFT default constant live in the shared define.v; the state encoding stays local.
REQ-029 The saturate/round stage is one sub-module, seek_e_round (combinational: work, round bit -> e), instantiated once.
REQ-030 No other sub-modules.

Verification (DW=14, SHIFT=3)
REQ-031 f=0x00028, en for 1 cycle -> rdy pulse exactly 4 edges later, e=0x0005.
REQ-032 f=0x0002C (5.5) -> e=0x0006; f=0x0002B (5.375) -> e=0x0005.
REQ-033 f=0x1FFFF -> with SEEK_E_SAT_EN e=0x3FFF; without it e=0x0000.
REQ-034 en held high for 12 cycles with f=0x00010 -> exactly two rdy pulses (e=0x0002 each), 5 cycles apart.
REQ-035 rst asserted for 1 cycle during SHIFT -> busy=0 and e=0 immediately, no rdy pulse, next request converts correctly.

Source files
------------

// File: rtl/seek_e_pkg.sv
// Shared constants for the seek_e scaled-to-integer converter.
// Holds the default result width and the default fractional shift.
package seek_e_pkg;

  localparam int DATAWIDTH = 14;
  localparam int SHIFT_DEF = 3;

endpackage

// File: rtl/seek_e_round.sv
// Round/saturate stage: adds the round bit to the shifted operand.
// Saturation to all ones is built only when SEEK_E_SAT_EN is defined.
module seek_e_round
  import seek_e_pkg::*;
#(
  parameter int DW = DATAWIDTH
) (
  input  logic [DW+2:0] work,
  input  logic          rb,
  output logic [DW-1:0] e
);

  logic [DW:0] sum;

  assign sum = work[DW:0] + {{DW{1'b0}}, rb};

`ifdef SEEK_E_SAT_EN
  logic sat;

  assign sat = sum[DW] | (|work[DW+2:DW]);

  // Clamp to the largest representable value on overflow
  always_comb begin
    e = sum[DW-1:0];
    if (sat) e = '1;
  end
`else
  logic unused_bits;

  assign unused_bits = ^{work[DW+2:DW+1], sum[DW]};

  // Overflow simply wraps into the low DW bits
  always_comb begin
    e = sum[DW-1:0];
  end
`endif

endmodule

// File: rtl/seek_e.sv
// seek_e: serial round(f / 2^SHIFT) converter with ready pulse.
// Define SEEK_E_SAT_EN to saturate on overflow instead of wrapping.
module seek_e
  import seek_e_pkg::*;
#(
  parameter int DW    = DATAWIDTH,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW+2:0] f,
  input  logic          en,
  output logic [DW-1:0] e,
  output logic          rdy,
  output logic          busy
);

  localparam int CW = $clog2(SHIFT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t        state, state_nx;
  logic [DW+2:0] work, work_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          rb, rb_nx;
  logic [DW-1:0] e_nx, e_rnd;
  logic          rdy_nx, busy_nx;

  seek_e_round #(
    .DW(DW)
  ) u_round (
    .work(work),
    .rb  (rb),
    .e   (e_rnd)
  );

  // Next-state and datapath updates for load, shift and finish
  always_comb begin
    state_nx = state;
    work_nx  = work;
    cnt_nx   = cnt;
    rb_nx    = rb;
    e_nx     = e;
    rdy_nx   = 1'b0;
    busy_nx  = busy;
    unique case (state)
      ST_IDLE: begin
        busy_nx = 1'b0;
        if (en) begin
          work_nx  = f;
          rb_nx    = 1'b0;
          cnt_nx   = CW'(SHIFT);
          busy_nx  = 1'b1;
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_nx = work >> 1;
        rb_nx   = work[0];
        cnt_nx  = cnt - CW'(1);
        if (cnt == CW'(1)) state_nx = ST_DONE;
      end
      ST_DONE: begin
        e_nx     = e_rnd;
        rdy_nx   = 1'b1;
        busy_nx  = 1'b0;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      work  <= '0;
      cnt   <= '0;
      rb    <= 1'b0;
      e     <= '0;
      rdy   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      work  <= work_nx;
      cnt   <= cnt_nx;
      rb    <= rb_nx;
      e     <= e_nx;
      rdy   <= rdy_nx;
      busy  <= busy_nx;
    end
  end

endmodule

// File: tb/tb_seek_e.sv
// Self-checking bench for seek_e (DW=14, SHIFT=3).
// Expected results are queued at request time and popped on rdy.
module tb_seek_e;

  localparam int DW = 14;
  localparam int SH = 3;
  localparam int FW = DW + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [FW-1:0] f;
  logic [DW-1:0] e;
  logic          rdy;
  logic          busy;

  typedef struct {
    logic [DW-1:0] val;
    int            at;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  int   rdy_cnt = 0;
  int   last_rdy = 0;
  int   prev_rdy = 0;

  seek_e #(
    .DW   (DW),
    .SHIFT(SH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .f   (f),
    .en  (en),
    .e   (e),
    .rdy (rdy),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] model(input logic [FW-1:0] x);
    logic [FW:0] s;
    s = {1'b0, x} >> SH;
    s = s + {{FW{1'b0}}, x[SH-1]};
`ifdef SEEK_E_SAT_EN
    if (s > ((1 << DW) - 1)) return '1;
`endif
    return s[DW-1:0];
  endfunction

  always @(negedge clk) begin
    if (rdy !== 1'b0) begin
      exp_t x;
      rdy_cnt++;
      prev_rdy = last_rdy;
      last_rdy = cyc;
      total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_rdy: rdy=%b at cycle %0d with nothing pending",
                 rdy, cyc);
      end else begin
        passed++;
        x = q.pop_front();
        total++;
        if (e !== x.val)
          $display("FAIL result: e=%h want %h", e, x.val);
        else
          passed++;
        total++;
        if (cyc !== x.at)
          $display("FAIL latency: rdy at cycle %0d want %0d", cyc, x.at);
        else
          passed++;
      end
    end
  end

  task automatic issue(input logic [FW-1:0] fv);
    @(negedge clk);
    f  = fv;
    en = 1'b1;
    @(posedge clk);
    #1;
    q.push_back('{model(fv), cyc + SH + 1});
    en = 1'b0;
    f  = FW'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain_timeout: %0d results pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    f   = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (e !== 14'h0) $display("FAIL reset_e: e=%h want 0000", e);
    else passed++;
    total++;
    if (rdy !== 1'b0) $display("FAIL reset_rdy: rdy=%b want 0", rdy);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: busy=%b want 0", busy);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    issue(17'h00028);
    drain();
    repeat (6) @(negedge clk);
    total++;
    if (e !== 14'h0005) $display("FAIL basic_hold: e=%h want 0005", e);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL idle_busy: busy=%b want 0", busy);
    else passed++;
  endtask

  task automatic test_round();
    issue(17'h0002C);
    drain();
    total++;
    if (e !== 14'h0006) $display("FAIL round_up: e=%h want 0006", e);
    else passed++;
    issue(17'h0002B);
    drain();
    total++;
    if (e !== 14'h0005) $display("FAIL round_down: e=%h want 0005", e);
    else passed++;
  endtask

  task automatic test_overflow();
    logic [DW-1:0] want;
`ifdef SEEK_E_SAT_EN
    want = 14'h3FFF;
`else
    want = 14'h0000;
`endif
    issue(17'h1FFFF);
    drain();
    total++;
    if (e !== want) $display("FAIL overflow: e=%h want %h", e, want);
    else passed++;
    issue(17'h1FFF0);
    drain();
    total++;
    if (e !== 14'h3FFE) $display("FAIL near_max: e=%h want 3ffe", e);
    else passed++;
  endtask

  task automatic test_busy_ignored();
    issue(17'h00040);
    @(negedge clk);
    f  = 17'h00100;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    drain();
    repeat (8) @(negedge clk);
    total++;
    if (e !== 14'h0008) $display("FAIL busy_ignore: e=%h want 0008", e);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      issue(FW'($urandom));
      drain();
    end
  endtask

  task automatic test_back_to_back();
    int start_cnt;
    int last_acc;
    start_cnt = rdy_cnt;
    last_acc = -100;
    @(negedge clk);
    f  = 17'h00010;
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (i - last_acc >= SH + 2) begin
        last_acc = i;
        q.push_back('{14'h0002, cyc + SH + 1});
      end
    end
    en = 1'b0;
    total++;
    if (rdy_cnt - start_cnt !== 2)
      $display("FAIL b2b_count: %0d pulses want 2", rdy_cnt - start_cnt);
    else
      passed++;
    total++;
    if (last_rdy - prev_rdy !== SH + 2)
      $display("FAIL b2b_gap: %0d cycles want %0d", last_rdy - prev_rdy, SH + 2);
    else
      passed++;
    drain();
  endtask

  task automatic test_reset_mid();
    issue(17'h00080);
    @(negedge clk);
    rst = 1'b1;
    #1;
    q.delete();
    total++;
    if (busy !== 1'b0) $display("FAIL mid_rst_busy: busy=%b want 0", busy);
    else passed++;
    total++;
    if (e !== 14'h0) $display("FAIL mid_rst_e: e=%h want 0000", e);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    issue(17'h00028);
    drain();
    total++;
    if (e !== 14'h0005) $display("FAIL post_rst: e=%h want 0005", e);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: run exceeded limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_overflow();
    test_busy_ignored();
    test_random();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
